// File: rtl/trap_ctrl.sv
// Trap controller: turns exceptions, interrupts and MRET into a flush / drain / commit / redirect sequence.
// Optional macro TRAP_VECTORED_EN: with mtvec[1:0]==1, interrupts redirect to base + 4*cause code.
module trap_ctrl (
    input  logic        ctrl_clk,
    input  logic        ctrl_reset_n,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic        irq_sw,
    input  logic        irq_timer,
    input  logic        irq_ext,
    input  logic        mie_msie,
    input  logic        mie_mtie,
    input  logic        mie_meie,
    input  logic        ctrl_mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic [31:0] next_pc,
    input  logic        mret_valid,
    input  logic        pipe_idle,
    output logic        pipe_stall,
    output logic        pipe_flush,
    output logic        ctrl_trap,
    output logic        ctrl_mret,
    output logic [31:0] trap_pc,
    output logic [4:0]  trap_info,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_COMMIT,
        S_REDIRECT
    } state_t;

    typedef enum logic [1:0] {
        K_EXC,
        K_IRQ,
        K_MRET
    } kind_t;

    state_t      r_state;
    state_t      w_state_next;
    kind_t       r_kind;
    logic [4:0]  r_cause;
    logic [31:0] r_pc;
    logic        r_flush;
    logic        r_ctrl_trap;
    logic        r_ctrl_mret;
    logic [31:0] r_trap_pc;
    logic [4:0]  r_trap_info;
    logic [31:0] r_redirect_pc;

    logic        w_irq_ext_en;
    logic        w_irq_sw_en;
    logic        w_irq_timer_en;
    logic        w_irq_any;
    logic [3:0]  w_irq_code;
    logic        w_event;
    logic        w_stall;
    logic        w_redirect_valid;
    logic [31:0] w_vec_offset;
    logic [31:0] w_target;
    logic        w_unused_bits;

    assign w_irq_ext_en   = ctrl_mie & irq_ext   & mie_meie;
    assign w_irq_sw_en    = ctrl_mie & irq_sw    & mie_msie;
    assign w_irq_timer_en = ctrl_mie & irq_timer & mie_mtie;
    assign w_irq_any      = w_irq_ext_en | w_irq_sw_en | w_irq_timer_en;
    assign w_irq_code     = w_irq_ext_en ? 4'd11 : (w_irq_sw_en ? 4'd3 : 4'd7);
    assign w_event        = exc_valid | w_irq_any | mret_valid;

    // Low address bits are architecturally ignored in the redirect targets.
    assign w_unused_bits  = &{1'b0, mtvec[1:0], mepc[1:0]};

`ifdef TRAP_VECTORED_EN
    assign w_vec_offset = ((mtvec[1:0] == 2'b01) && (r_kind == K_IRQ))
                        ? {26'd0, r_cause[3:0], 2'b00} : 32'd0;
`else
    assign w_vec_offset = 32'd0;
`endif

    assign w_target = (r_kind == K_MRET) ? {mepc[31:2], 2'b00}
                                         : ({mtvec[31:2], 2'b00} + w_vec_offset);

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_stall          = 1'b1;
        w_redirect_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = 1'b0;
                if (w_event) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pipe_idle) begin
                    w_state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_state_next = S_REDIRECT;
            end
            S_REDIRECT: begin
                w_redirect_valid = 1'b1;
                if (redirect_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_kind        <= K_EXC;
            r_cause       <= 5'd0;
            r_pc          <= 32'd0;
            r_flush       <= 1'b0;
            r_ctrl_trap   <= 1'b0;
            r_ctrl_mret   <= 1'b0;
            r_trap_pc     <= 32'd0;
            r_trap_info   <= 5'd0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_flush     <= 1'b0;
            r_ctrl_trap <= 1'b0;
            r_ctrl_mret <= 1'b0;
            if ((r_state == S_IDLE) && w_event) begin
                r_flush <= 1'b1;
                if (exc_valid) begin
                    r_kind  <= K_EXC;
                    r_cause <= {1'b0, exc_cause};
                    r_pc    <= exc_pc;
                end else if (w_irq_any) begin
                    r_kind  <= K_IRQ;
                    r_cause <= {1'b1, w_irq_code};
                    r_pc    <= next_pc;
                end else begin
                    r_kind  <= K_MRET;
                end
            end
            // Commit strobes are registered so they are high for exactly the COMMIT cycle.
            if ((r_state == S_DRAIN) && (w_state_next == S_COMMIT)) begin
                if (r_kind == K_MRET) begin
                    r_ctrl_mret <= 1'b1;
                end else begin
                    r_ctrl_trap <= 1'b1;
                    r_trap_pc   <= r_pc;
                    r_trap_info <= r_cause;
                end
            end
            if (r_state == S_COMMIT) begin
                r_redirect_pc <= w_target;
            end
        end
    end

    assign pipe_stall     = w_stall;
    assign pipe_flush     = r_flush;
    assign ctrl_trap      = r_ctrl_trap;
    assign ctrl_mret      = r_ctrl_mret;
    assign trap_pc        = r_trap_pc;
    assign trap_info      = r_trap_info;
    assign redirect_valid = w_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have port: ctrl_clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port: ctrl_reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: exc_valid in 1, exc_cause in 4, exc_pc in 32  synchronous exception from retiring instruction.
REQ-004 SHALL have ports: irq_sw, irq_timer, irq_ext  in  1 each  level-sensitive interrupt lines.
REQ-005 SHALL have ports: mie_msie, mie_mtie, mie_meie  in  1 each  CSR mie bits 3/7/11; ctrl_mie  in  1  mstatus.MIE.
REQ-006 SHALL have ports: mtvec in 32, mepc in 32  current CSR values; next_pc in 32  PC of next unretired instruction.
REQ-007 SHALL have ports: mret_valid in 1  MRET retiring; pipe_idle in 1  pipeline drained, no CSR access in flight.
REQ-008 SHALL have ports: pipe_stall out 1, pipe_flush out 1  front-end hold and one-cycle flush pulse.
REQ-009 SHALL have ports: ctrl_trap out 1, ctrl_mret out 1, trap_pc out 32, trap_info out 5  drive the CSR file trap interface.
REQ-010 SHALL have ports: redirect_valid out 1, redirect_pc out 32, redirect_ready in 1  fetch redirect handshake.

Function
REQ-011 SHALL implement FSM states IDLE, DRAIN, COMMIT, REDIRECT.
REQ-012 IDLE: event priority exc_valid > enabled interrupt > mret_valid; any event latches kind/cause/pc, pulses pipe_flush one cycle, moves to DRAIN.
REQ-013 Interrupt enabled SHALL mean ctrl_mie=1 and (irq_x & mie_x) for some x; priority ext(11) > sw(3) > timer(7); latched pc = next_pc.
REQ-014 Exception latched pc = exc_pc, cause = {0, exc_cause}; interrupt cause = {1, code[3:0]}.
REQ-015 DRAIN: hold until pipe_idle=1, then COMMIT; pipe_idle already 1 on entry still costs one DRAIN cycle.
REQ-016 COMMIT (exactly one cycle): trap kinds pulse ctrl_trap with trap_pc=latched pc, trap_info=latched cause; MRET pulses ctrl_mret only.
REQ-017 redirect_pc computed in COMMIT: MRET -> {mepc[31:2],00}; trap -> {mtvec[31:2],00} (+4*code per Configuration).
REQ-018 REDIRECT: redirect_valid=1, redirect_pc stable until redirect_ready=1; then IDLE next cycle.
REQ-019 pipe_stall SHALL be 1 in DRAIN, COMMIT, REDIRECT; 0 in IDLE.
REQ-020 Events outside IDLE SHALL be ignored; interrupt deassertion after latch SHALL NOT cancel the trap.
REQ-021 ctrl_trap and ctrl_mret SHALL never be 1 in the same cycle; trap_pc/trap_info hold last values outside COMMIT.
REQ-022 Minimum event-to-redirect_valid latency: 3 cycles (latch, DRAIN, COMMIT).

Reset
REQ-023 ctrl_reset_n=0 SHALL immediately force IDLE and all outputs (incl. 32-bit ones) to 0, regardless of clock.
REQ-024 Reset mid-sequence SHALL abandon the event with no ctrl_trap/ctrl_mret pulse; first event accepted on first edge after release.

Configuration
REQ-025 Macro TRAP_VECTORED_EN defined: mtvec[1:0]=1 and interrupt -> redirect_pc = {mtvec[31:2],00} + 4*code; exceptions use base.
REQ-026 TRAP_VECTORED_EN undefined: mtvec[1:0] ignored; all traps redirect to {mtvec[31:2],00}.

Verification
REQ-027 exc_valid, exc_cause=2, exc_pc=0x100, mtvec=0x8000, pipe_idle=1 -> ctrl_trap pulse, trap_pc=0x100, trap_info=0x02, redirect_pc=0x8000.
REQ-028 irq_timer=1, mie_mtie=1, ctrl_mie=1, next_pc=0x204, mtvec=0x8001 -> trap_info=0x17; redirect_pc=0x801C with macro, 0x8000 without.
REQ-029 irq_ext+irq_sw+exc_valid(cause 11) same cycle -> exception wins, trap_info=0x0B; ctrl_mie=0 with irq_ext alone -> no event.
REQ-030 mret_valid, mepc=0x306 -> ctrl_mret one cycle, no ctrl_trap, redirect_pc=0x304.
REQ-031 pipe_idle low 5 cycles, redirect_ready low 3 cycles -> stall held throughout, redirect_pc stable, return to IDLE after ready.
REQ-032 ctrl_reset_n low during DRAIN -> outputs 0 asynchronously, no COMMIT pulse; new exception after release handled normally.
